// File: rtl/lif_injector_if.sv
// ---------------------------------------------------------------------------
// lif_injector_if
//
// Purpose: bundles the byte-producer handshake and the lane-side outputs of
// the LIF pulse injector into one interface.
//
// Signals:
//   tx_data     [7:0]  byte to inject (producer -> injector)
//   tx_valid           producer offers tx_data (producer -> injector)
//   tx_ready           injector can accept a byte this cycle (injector -> producer)
//   gap_cycles  [2:0]  quiet-cycle count G, latched with the byte (producer -> injector)
//   lane        [3:0]  registered pulse pattern for the edge-cell neighbour input
//   busy               frame in progress (inverse of tx_ready)
//   done               single-cycle pulse in the first idle cycle after a frame
//
// Modports:
//   master - producer side (drives tx_data/tx_valid/gap_cycles)
//   slave  - injector side (drives tx_ready/lane/busy/done)
// ---------------------------------------------------------------------------
interface lif_injector_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [2:0] gap_cycles;
    logic [3:0] lane;
    logic       busy;
    logic       done;

    modport master (
        output tx_data,
        output tx_valid,
        output gap_cycles,
        input  tx_ready,
        input  lane,
        input  busy,
        input  done
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  gap_cycles,
        output tx_ready,
        output lane,
        output busy,
        output done
    );
endinterface

// File: rtl/lif_injector.sv
// ---------------------------------------------------------------------------
// lif_injector
//
// Purpose: serialises one byte into a frame of 4-bit pulse symbols on a lane
// that feeds an edge cell's neighbour input. A frame is START, data bits 0..7
// (LSB first), an optional PARITY symbol, and STOP. Every symbol is driven for
// one cycle and followed by G+1 quiet (4'b0000) cycles, where G is the
// gap_cycles value latched when the byte is accepted.
//
// Ports:
//   clk    - rising-edge clock for all state
//   rst_n  - synchronous, active-low reset; aborts any frame without a done
//   bus    - lif_injector_if.slave
//              tx_data/tx_valid/tx_ready : byte handshake (accept when both high)
//              gap_cycles                : G, latched on the accept edge
//              lane                      : registered symbol output
//              busy                      : frame in progress
//              done                      : one-cycle pulse after a frame ends
//
// Build option:
//   LIF_INJ_PARITY_EN - when defined, a PARITY symbol (bit one if the XOR of
//                       the data bits is 1, else bit zero) follows bit 7,
//                       giving 11 symbols per frame instead of 10.
// ---------------------------------------------------------------------------
module lif_injector (
    input  logic          clk,
    input  logic          rst_n,
    lif_injector_if.slave bus
);

    localparam int DATA_W = 8;

`ifdef LIF_INJ_PARITY_EN
    localparam int NUM_SYM = DATA_W + 3;
`else
    localparam int NUM_SYM = DATA_W + 2;
`endif

    localparam logic [3:0] LAST_SYM = 4'(NUM_SYM - 1);

    localparam logic [3:0] SYM_START = 4'b1010;
    localparam logic [3:0] SYM_ONE   = 4'b0100;
    localparam logic [3:0] SYM_ZERO  = 4'b0001;
    localparam logic [3:0] SYM_STOP  = 4'b0101;
    localparam logic [3:0] SYM_QUIET = 4'b0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYM   = 2'd1,
        QUIET = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [3:0]          sym_idx;
    logic [3:0]          sym_idx_next;
    logic [2:0]          quiet_cnt;
    logic [2:0]          quiet_cnt_next;
    logic [DATA_W-1:0]   data_reg;
    logic [DATA_W-1:0]   data_next;
    logic [2:0]          gap_reg;
    logic [2:0]          gap_next;
    logic [3:0]          lane_reg;
    logic [3:0]          lane_next;
    logic                done_reg;
    logic                done_next;

    // Symbol index 0 is START, 1..8 are data bits 0..7, then PARITY (if
    // built in), and the last index is STOP.
    function automatic logic [3:0] sym_code(input logic [3:0]        idx,
                                            input logic [DATA_W-1:0] data);
        logic [3:0] code;
        logic [2:0] bit_sel;
        code    = SYM_STOP;
        bit_sel = 3'(idx - 4'd1);
        if (idx == 4'd0) begin
            code = SYM_START;
        end else if (idx <= 4'(DATA_W)) begin
            code = data[bit_sel] ? SYM_ONE : SYM_ZERO;
        end
`ifdef LIF_INJ_PARITY_EN
        else if (idx == 4'(DATA_W + 1)) begin
            code = (^data) ? SYM_ONE : SYM_ZERO;
        end
`endif
        return code;
    endfunction

    // Next-state and next-output logic. lane is computed for the state being
    // entered so the registered lane lines up with the registered state:
    // START appears in the first cycle after the accept edge.
    always_comb begin
        state_next     = state;
        sym_idx_next   = sym_idx;
        quiet_cnt_next = quiet_cnt;
        data_next      = data_reg;
        gap_next       = gap_reg;
        lane_next      = SYM_QUIET;
        done_next      = 1'b0;

        case (state)
            IDLE: begin
                if (bus.tx_valid) begin
                    data_next      = bus.tx_data;
                    gap_next       = bus.gap_cycles;
                    sym_idx_next   = 4'd0;
                    quiet_cnt_next = 3'd0;
                    lane_next      = SYM_START;
                    state_next     = SYM;
                end
            end

            SYM: begin
                quiet_cnt_next = 3'd0;
                state_next     = QUIET;
            end

            QUIET: begin
                // quiet_cnt runs 0..G, giving G+1 quiet cycles per symbol.
                if (quiet_cnt == gap_reg) begin
                    if (sym_idx == LAST_SYM) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        sym_idx_next = sym_idx + 4'd1;
                        lane_next    = sym_code(sym_idx + 4'd1, data_reg);
                        state_next   = SYM;
                    end
                end else begin
                    quiet_cnt_next = quiet_cnt + 3'd1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // The index never moves past STOP, even if the state is disturbed.
        if (sym_idx_next > LAST_SYM) begin
            sym_idx_next = LAST_SYM;
        end
    end

    // State and output registers. Reset clears everything, including the
    // latched byte, so an aborted frame leaves no trace.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sym_idx   <= 4'd0;
            quiet_cnt <= 3'd0;
            data_reg  <= '0;
            gap_reg   <= 3'd0;
            lane_reg  <= SYM_QUIET;
            done_reg  <= 1'b0;
        end else begin
            state     <= state_next;
            sym_idx   <= sym_idx_next;
            quiet_cnt <= quiet_cnt_next;
            data_reg  <= data_next;
            gap_reg   <= gap_next;
            lane_reg  <= lane_next;
            done_reg  <= done_next;
        end
    end

    assign bus.tx_ready = (state == IDLE);
    assign bus.busy     = (state != IDLE);
    assign bus.lane     = lane_reg;
    assign bus.done     = done_reg;

endmodule

// File: doc/lif_injector.md
LIF_INJECTOR -- requirements
Module: lif_injector

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst_n  input  1  reset, synchronous, active-low; sampled on the rising edge of clk.
REQ-003 tx_data  input  8  byte to inject; sampled only on the accept edge.
REQ-004 tx_valid  input  1  producer offers tx_data.
REQ-005 tx_ready  output  1  injector can accept a byte this cycle.
REQ-006 gap_cycles  input  3  quiet-cycle count G; sampled only on the accept edge.
REQ-007 lane  output  4  pulse pattern driven onto an edge cell neighbour input; registered.
REQ-008 busy  output  1  high while a frame is in progress.
REQ-009 done  output  1  single-cycle pulse at frame completion.

Function
REQ-010 Accept SHALL occur on a rising edge where tx_valid=1 and tx_ready=1; the injector SHALL latch tx_data and G on that edge.
REQ-011 tx_ready SHALL be 1 exactly when the state is IDLE; busy SHALL equal the inverse of tx_ready.
REQ-012 Symbol encodings SHALL be: START=4'b1010, bit one=4'b0100, bit zero=4'b0001, STOP=4'b0101, quiet=4'b0000.
REQ-013 The frame SHALL be, in order: START, data bits 0 to 7 (LSB first), [PARITY per REQ-024], STOP.
REQ-014 Each symbol SHALL be driven for exactly 1 cycle and SHALL be followed by exactly G+1 quiet cycles.
REQ-015 The state machine SHALL have states IDLE, SYM, QUIET.
REQ-016 Transitions SHALL be: IDLE->SYM on accept; SYM->QUIET always; QUIET->SYM when the quiet counter reaches G and symbols remain; QUIET->IDLE when the quiet counter reaches G after STOP.
REQ-017 lane SHALL show START in the first cycle after the accept edge.
REQ-018 With N symbols, frame length SHALL be N*(G+2) cycles, counted from the first cycle after accept.
REQ-019 done SHALL be 1 only in the first IDLE cycle after a completed frame, and tx_ready SHALL be 1 in that same cycle.
REQ-020 A byte accepted in the done cycle SHALL start the next frame with no idle gap.
REQ-021 Changes on tx_valid, tx_data or gap_cycles during a frame SHALL have no effect on the frame in progress.
REQ-022 The symbol index counter SHALL NOT wrap; it saturates at the final symbol.
REQ-023 lane SHALL be 4'b0000 in IDLE.

Configuration
REQ-024 The PARITY symbol SHALL be compiled in only when macro LIF_INJ_PARITY_EN is defined.
- Defined: a PARITY symbol follows bit 7, encoded as bit one if the XOR of all 8 data bits is 1, otherwise bit zero; N=11.
- Undefined: no PARITY symbol is sent and N=10.

Reset
REQ-025 With rst_n=0 at a clock edge, the following SHALL hold in the next cycle: state IDLE, lane=4'b0000, tx_ready=1, busy=0, done=0, and all counters and latched data cleared.
REQ-026 Reset mid-frame SHALL abort the frame with no done pulse; the aborted byte is never resumed.
REQ-027 Reset SHALL take priority over accept in the same cycle.

Verification
REQ-028 Basic frame: tx_data=8'hA5, G=0, parity off. lane SHALL show, on every 2nd cycle, 1010, 0100, 0001, 0100, 0001, 0001, 0100, 0001, 0100, 0101, with 0000 between; done SHALL pulse in cycle 21.
REQ-029 Gap timing: tx_data=8'h00, G=7. Every symbol SHALL be followed by 8 quiet cycles; total frame length 90 cycles; tx_ready=0 throughout.
REQ-030 Back-to-back: tx_valid held high with 8'h01 then 8'hFF. The second START SHALL appear in the cycle after done; tx_data changes mid-frame SHALL not alter the first frame.
REQ-031 Parity (LIF_INJ_PARITY_EN defined): 8'h07 gives PARITY=0100; 8'h03 gives PARITY=0001; frame length with G=0 SHALL be 22 cycles.
REQ-032 Reset abort: rst_n=0 during bit 4. Next cycle SHALL show lane=0000, tx_ready=1, done=0; a following byte SHALL transmit a complete, correct frame.
